// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline (F,D,X,M,W).
//   Merges load-use stalls, X-stage branch redirects and multi-cycle dmem
//   waits into per-stage register enables and bubble inserts. Flags a
//   dmem timeout (sticky HALT) and counts front-end stall cycles.
//
//   Ports
//     clk, rst_n     clock (rising edge), async active-low reset
//     load_use       load-use stall request from hazard unit
//     br_taken_X     branch/jump resolved taken in X this cycle
//     dmem_req       M-stage instruction is a load/store
//     dmem_ack       data memory completes the M access this cycle
//     en_F..en_M     pipeline register write enables
//     flush_D/X/W    bubble insert into IF/ID, ID/EX, MEM/WB
//     halted         sticky dmem timeout, pipeline frozen
//     stall_cycles   saturating count of cycles with en_F==0
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             br_taken_X,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             en_F,
    output logic             en_D,
    output logic             en_X,
    output logic             en_M,
    output logic             flush_D,
    output logic             flush_X,
    output logic             flush_W,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DWAIT = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [WC_W-1:0]   w_wait_nxt;
    logic [CNT_W-1:0]  r_stall_cnt;

    // w_issue: the M access is not blocking this cycle, so the normal
    // branch / load-use / advance priority decides the enables.
    logic w_issue;
    logic w_en_F, w_en_D, w_en_X, w_en_M;
    logic w_fl_D, w_fl_X, w_fl_W, w_halt;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // ---------------- next state / outputs ----------------
    always_comb begin
        w_next     = r_state;
        w_wait_nxt = r_wait_cnt;
        w_issue    = 1'b0;
        w_fl_W     = 1'b0;
        w_halt     = 1'b0;

        case (r_state)
            S_RUN: begin
                if (dmem_req && !dmem_ack) begin
                    w_fl_W     = 1'b1;
                    w_next     = S_DWAIT;
                    w_wait_nxt = WC_W'(1);
                end else begin
                    // includes the zero-wait case (req with same-cycle ack)
                    w_issue = 1'b1;
                end
            end
            S_DWAIT: begin
                if (dmem_ack) begin
                    // exit cycle: branch/load-use held during the wait are
                    // still present on the inputs and are serviced now
                    w_issue    = 1'b1;
                    w_next     = S_RUN;
                    w_wait_nxt = '0;
                end else begin
                    w_fl_W     = 1'b1;
                    w_wait_nxt = r_wait_cnt + WC_W'(1);
                    if (r_wait_cnt == WC_W'(TIMEOUT - 1))
                        w_next = S_HALT;
                end
            end
            S_HALT: begin
                w_halt = 1'b1;
            end
            default: begin
                w_next     = S_RUN;
                w_wait_nxt = '0;
            end
        endcase
    end

    // Enable / flush decode once the M access is known not to block.
    always_comb begin
        w_en_F = 1'b0;
        w_en_D = 1'b0;
        w_en_X = 1'b0;
        w_en_M = 1'b0;
        w_fl_D = 1'b0;
        w_fl_X = 1'b0;
        if (w_issue) begin
            if (br_taken_X) begin
                // redirect squashes D, so a concurrent load_use is moot
                w_en_F = 1'b1;
                w_en_D = 1'b1;
                w_en_X = 1'b1;
                w_en_M = 1'b1;
                w_fl_D = 1'b1;
                w_fl_X = 1'b1;
            end else if (load_use) begin
                // hold F/D, let the load move on, bubble into X
                w_en_X = 1'b1;
                w_en_M = 1'b1;
                w_fl_X = 1'b1;
            end else begin
                w_en_F = 1'b1;
                w_en_D = 1'b1;
                w_en_X = 1'b1;
                w_en_M = 1'b1;
            end
        end
    end

    // ---------------- stall counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (!w_en_F && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    // Outputs forced quiet while reset is held, independent of the clock.
    assign en_F         = rst_n & w_en_F;
    assign en_D         = rst_n & w_en_D;
    assign en_X         = rst_n & w_en_X;
    assign en_M         = rst_n & w_en_M;
    assign flush_D      = rst_n & w_fl_D;
    assign flush_X      = rst_n & w_fl_X;
    assign flush_W      = rst_n & w_fl_W;
    assign halted       = rst_n & w_halt;
    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic load_use, br_taken_X, dmem_req, dmem_ack;
    logic en_F, en_D, en_X, en_M, flush_D, flush_X, flush_W, halted;
    logic [31:0] stall_cycles;

    // second instance for counter saturation with a narrow counter
    logic load_use4;
    logic en_F4, en_D4, en_X4, en_M4, flush_D4, flush_X4, flush_W4, halted4;
    logic [3:0] stall4;

    logic [7:0] outs;
    logic [7:0] outs4;
    int n_cmp = 0;
    int n_err = 0;

    // outs: {en_F,en_D,en_X,en_M,flush_D,flush_X,flush_W,halted}
    localparam logic [7:0] O_RUN    = 8'b1111_0000;
    localparam logic [7:0] O_FROZEN = 8'b0000_0010;
    localparam logic [7:0] O_BR     = 8'b1111_1100;
    localparam logic [7:0] O_HALT   = 8'b0000_0001;
    localparam logic [7:0] O_ZERO   = 8'b0000_0000;
    // load-use: en_X not constrained, masked out
    localparam logic [7:0] M_LU     = 8'b1101_1111;
    localparam logic [7:0] O_LU     = 8'b0001_0100;

    assign outs  = {en_F, en_D, en_X, en_M, flush_D, flush_X, flush_W, halted};
    assign outs4 = {en_F4, en_D4, en_X4, en_M4, flush_D4, flush_X4, flush_W4, halted4};

    always #5 clk = ~clk;

    pipeline_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .load_use(load_use), .br_taken_X(br_taken_X),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .en_F(en_F), .en_D(en_D), .en_X(en_X), .en_M(en_M),
        .flush_D(flush_D), .flush_X(flush_X), .flush_W(flush_W),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    pipeline_ctrl #(.TIMEOUT(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .load_use(load_use4), .br_taken_X(1'b0),
        .dmem_req(1'b0), .dmem_ack(1'b0),
        .en_F(en_F4), .en_D(en_D4), .en_X(en_X4), .en_M(en_M4),
        .flush_D(flush_D4), .flush_X(flush_X4), .flush_W(flush_W4),
        .halted(halted4), .stall_cycles(stall4)
    );

    // one cycle: drive just after the rising edge, look at the falling edge
    task automatic step(input logic lu, input logic br, input logic req, input logic ack);
        @(posedge clk);
        #1;
        load_use   = lu;
        br_taken_X = br;
        dmem_req   = req;
        dmem_ack   = ack;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_use = 0; br_taken_X = 0; dmem_req = 0; dmem_ack = 0; load_use4 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (outs !== O_ZERO || stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL reset_hold: outs=%b stall=%0d, want %b stall=0", outs, stall_cycles, O_ZERO);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (outs !== O_RUN || stall_cycles !== 32'd0) begin
                n_err++;
                $display("FAIL reset_run[%0d]: outs=%b stall=%0d, want %b stall=0", i, outs, stall_cycles, O_RUN);
            end
        end
    endtask

    task automatic test_load_use();
        step(1, 0, 0, 0);
        n_cmp++;
        if ((outs & M_LU) !== O_LU) begin
            n_err++;
            $display("FAIL load_use: outs=%b, want %b (en_X masked)", outs, O_LU);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (outs !== O_RUN || stall_cycles !== 32'd1) begin
            n_err++;
            $display("FAIL load_use_after: outs=%b stall=%0d, want %b stall=1", outs, stall_cycles, O_RUN);
        end
    endtask

    task automatic test_branch();
        step(1, 1, 0, 0);
        n_cmp++;
        if (outs !== O_BR) begin
            n_err++;
            $display("FAIL branch_lu: outs=%b, want %b", outs, O_BR);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (stall_cycles !== 32'd1) begin
            n_err++;
            $display("FAIL branch_stall: stall=%0d, want 1", stall_cycles);
        end
    endtask

    task automatic test_dmem_wait();
        // ack arrives on the 4th cycle: three frozen cycles
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            n_cmp++;
            if (outs !== O_FROZEN) begin
                n_err++;
                $display("FAIL dwait_frozen[%0d]: outs=%b, want %b", i, outs, O_FROZEN);
            end
        end
        step(0, 0, 1, 1);
        n_cmp++;
        if (outs !== O_RUN) begin
            n_err++;
            $display("FAIL dwait_exit: outs=%b, want %b", outs, O_RUN);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (outs !== O_RUN || stall_cycles !== 32'd4) begin
            n_err++;
            $display("FAIL dwait_stall: outs=%b stall=%0d, want %b stall=4", outs, stall_cycles, O_RUN);
        end
    endtask

    task automatic test_dwait_events();
        // branch held during a wait is serviced on the exit cycle
        step(0, 1, 1, 0);
        n_cmp++;
        if (outs !== O_FROZEN) begin
            n_err++;
            $display("FAIL dwait_br_hold: outs=%b, want %b", outs, O_FROZEN);
        end
        step(0, 1, 1, 1);
        n_cmp++;
        if (outs !== O_BR) begin
            n_err++;
            $display("FAIL dwait_br_exit: outs=%b, want %b", outs, O_BR);
        end
        // zero-wait access in RUN
        step(0, 0, 1, 1);
        n_cmp++;
        if (outs !== O_RUN || stall_cycles !== 32'd5) begin
            n_err++;
            $display("FAIL zero_wait: outs=%b stall=%0d, want %b stall=5", outs, stall_cycles, O_RUN);
        end
        // dmem block outranks load_use; load_use serviced on exit
        step(1, 0, 1, 0);
        n_cmp++;
        if (outs !== O_FROZEN) begin
            n_err++;
            $display("FAIL dwait_lu_hold: outs=%b, want %b", outs, O_FROZEN);
        end
        step(1, 0, 1, 1);
        n_cmp++;
        if ((outs & M_LU) !== O_LU) begin
            n_err++;
            $display("FAIL dwait_lu_exit: outs=%b, want %b (en_X masked)", outs, O_LU);
        end
        step(0, 0, 0, 0);
        n_cmp++;
        if (outs !== O_RUN || stall_cycles !== 32'd7) begin
            n_err++;
            $display("FAIL dwait_ev_stall: outs=%b stall=%0d, want %b stall=7", outs, stall_cycles, O_RUN);
        end
    endtask

    task automatic test_timeout();
        // 16 frozen cycles (1 RUN + 15 DWAIT) then HALT
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0);
            n_cmp++;
            if (outs !== O_FROZEN) begin
                n_err++;
                $display("FAIL timeout_wait[%0d]: outs=%b, want %b", i, outs, O_FROZEN);
            end
        end
        step(0, 0, 1, 0);
        n_cmp++;
        if (outs !== O_HALT) begin
            n_err++;
            $display("FAIL timeout_halt: outs=%b, want %b", outs, O_HALT);
        end
        // late ack and branch are ignored
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 1);
            n_cmp++;
            if (outs !== O_HALT) begin
                n_err++;
                $display("FAIL halt_sticky[%0d]: outs=%b, want %b", i, outs, O_HALT);
            end
        end
        // 7 before + 19 stalled edges seen so far
        n_cmp++;
        if (stall_cycles !== 32'd26) begin
            n_err++;
            $display("FAIL halt_stall: stall=%0d, want 26", stall_cycles);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs !== O_ZERO || stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL halt_async_rst: outs=%b stall=%0d, want %b stall=0", outs, stall_cycles, O_ZERO);
        end
        #1;
        rst_n = 1'b1; load_use = 0; br_taken_X = 0; dmem_req = 0; dmem_ack = 0;
        @(negedge clk);
        n_cmp++;
        if (outs !== O_RUN || stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL halt_cleared: outs=%b stall=%0d, want %b stall=0", outs, stall_cycles, O_RUN);
        end
    endtask

    task automatic test_reset_mid_dwait();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        n_cmp++;
        if (outs !== O_FROZEN) begin
            n_err++;
            $display("FAIL mid_dwait: outs=%b, want %b", outs, O_FROZEN);
        end
        @(posedge clk);
        #1 rst_n = 1'b0; dmem_req = 0;
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0);
        n_cmp++;
        if (outs !== O_RUN || stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL mid_dwait_rst: outs=%b stall=%0d, want %b stall=0", outs, stall_cycles, O_RUN);
        end
    endtask

    task automatic test_saturate();
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1 load_use4 = 1'b1;
            @(negedge clk);
            // at cycle i's falling edge, i-1 stalled edges have passed
            if (i == 10) begin
                n_cmp++;
                if (stall4 !== 4'd9) begin
                    n_err++;
                    $display("FAIL sat_mid: stall=%0d, want 9", stall4);
                end
            end
            if (i == 16) begin
                n_cmp++;
                if (stall4 !== 4'd15 || (outs4 & M_LU) !== O_LU) begin
                    n_err++;
                    $display("FAIL sat_reach: stall=%0d outs=%b, want 15 %b", stall4, outs4, O_LU);
                end
            end
        end
        @(posedge clk);
        #1 load_use4 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stall4 !== 4'd15 || outs4 !== O_RUN) begin
            n_err++;
            $display("FAIL sat_hold: stall=%0d outs=%b, want 15 %b", stall4, outs4, O_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_dmem_wait();
        test_dwait_events();
        test_timeout();
        test_reset_mid_dwait();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
